// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Feeds RX operand bytes pairwise to the shared ALU, accumulates the
//            result in A and streams the final word LSB-first onto TX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
   parameter int unsigned WIDTH_P = 32
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic [1:0]         opcode_i,
   input  logic [15:0]        length_i,
   input  logic               valid_i,
   input  logic [7:0]         data_i,
   output logic               ready_o,
   output logic               alu_valid_o,
   input  logic               alu_ready_i,
   output logic [1:0]         alu_opcode_o,
   output logic [WIDTH_P-1:0] alu_a_o,
   output logic [WIDTH_P-1:0] alu_b_o,
   input  logic               alu_valid_i,
   input  logic [WIDTH_P-1:0] alu_result_i,
   output logic               alu_ready_o,
   output logic               valid_o,
   output logic [7:0]         data_o,
   input  logic               ready_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               error_o
);

   localparam int unsigned c_BYTES = WIDTH_P / 8;
   localparam int unsigned c_IDX_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
   localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_BYTES - 1);
   localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_ISSUE  = 3'd3,
      S_WAIT   = 3'd4,
      S_SEND   = 3'd5
   } state_t;

   state_t               r_state;
   logic [15:0]          r_count;
   logic [15:0]          r_length;
   logic [1:0]           r_opcode;
   logic [WIDTH_P-1:0]   r_a;
   logic [WIDTH_P-1:0]   r_b;
   logic [c_IDX_W-1:0]   r_bidx;
   logic [c_IDX_W-1:0]   r_tidx;
   logic                 r_ready;
   logic                 r_alu_valid;
   logic                 r_alu_ready;
   logic                 r_valid;
   logic [7:0]           r_data;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_error;

   logic                 w_len_ok;
   logic                 w_rx_fire;
   logic                 w_byte_last;
   logic [c_IDX_W-1:0]   w_bidx_next;
   logic [c_IDX_W-1:0]   w_tidx_next;
   logic [7:0]           w_tx_next_byte;

   // Need at least two operand words and only whole words.
   assign w_len_ok       = (32'(length_i) >= 2 * c_BYTES) &&
                           ((32'(length_i) % c_BYTES) == 32'd0);
   assign w_rx_fire      = valid_i & r_ready;
   assign w_byte_last    = (r_bidx == c_IDX_LAST);
   assign w_bidx_next    = w_byte_last ? '0 : r_bidx + c_IDX_ONE;
   assign w_tidx_next    = r_tidx + c_IDX_ONE;
   assign w_tx_next_byte = r_a[32'(w_tidx_next) * 8 +: 8];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_length    <= '0;
         r_opcode    <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_bidx      <= '0;
         r_tidx      <= '0;
         r_ready     <= 1'b0;
         r_alu_valid <= 1'b0;
         r_alu_ready <= 1'b0;
         r_valid     <= 1'b0;
         r_data      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  if (w_len_ok) begin
                     r_opcode <= opcode_i;
                     r_length <= length_i;
                     r_count  <= '0;
                     r_bidx   <= '0;
                     r_ready  <= 1'b1;
                     r_busy   <= 1'b1;
                     r_state  <= S_LOAD_A;
                  end else begin
                     r_error <= 1'b1;
                  end
               end
            end

            S_LOAD_A: begin
               if (w_rx_fire) begin
                  r_a[32'(r_bidx) * 8 +: 8] <= data_i;
                  r_count <= r_count + 16'd1;
                  r_bidx  <= w_bidx_next;
                  if (w_byte_last) begin
                     r_state <= S_LOAD_B;
                  end
               end
            end

            S_LOAD_B: begin
               if (w_rx_fire) begin
                  r_b[32'(r_bidx) * 8 +: 8] <= data_i;
                  r_count <= r_count + 16'd1;
                  r_bidx  <= w_bidx_next;
                  if (w_byte_last) begin
                     r_ready     <= 1'b0;
                     r_alu_valid <= 1'b1;
                     r_state     <= S_ISSUE;
                  end
               end
            end

            S_ISSUE: begin
               if (alu_ready_i) begin
                  r_alu_valid <= 1'b0;
                  r_alu_ready <= 1'b1;
                  r_state     <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (alu_valid_i) begin
                  // A becomes the accumulator for any further operand words.
                  r_a         <= alu_result_i;
                  r_alu_ready <= 1'b0;
                  if (r_count == r_length) begin
                     r_tidx  <= '0;
                     r_data  <= alu_result_i[7:0];
                     r_valid <= 1'b1;
                     r_state <= S_SEND;
                  end else begin
                     r_ready <= 1'b1;
                     r_state <= S_LOAD_B;
                  end
               end
            end

            S_SEND: begin
               if (ready_i) begin
                  if (r_tidx == c_IDX_LAST) begin
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_tidx <= w_tidx_next;
                     r_data <= w_tx_next_byte;
                  end
               end
            end

            default: begin
               r_ready     <= 1'b0;
               r_alu_valid <= 1'b0;
               r_alu_ready <= 1'b0;
               r_valid     <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign ready_o      = r_ready;
   assign alu_valid_o  = r_alu_valid;
   assign alu_opcode_o = r_opcode;
   assign alu_a_o      = r_a;
   assign alu_b_o      = r_b;
   assign alu_ready_o  = r_alu_ready;
   assign valid_o      = r_valid;
   assign data_o       = r_data;
   assign busy_o       = r_busy;
   assign done_o       = r_done;
   assign error_o      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Directed self-checking bench for alu_op_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        start_i = 1'b0;
   logic [1:0]  opcode_i = '0;
   logic [15:0] length_i = '0;
   logic        valid_i = 1'b0;
   logic [7:0]  data_i = '0;
   logic        ready_o;
   logic        alu_valid_o;
   logic        alu_ready_i = 1'b0;
   logic [1:0]  alu_opcode_o;
   logic [31:0] alu_a_o;
   logic [31:0] alu_b_o;
   logic        alu_valid_i = 1'b0;
   logic [31:0] alu_result_i = '0;
   logic        alu_ready_o;
   logic        valid_o;
   logic [7:0]  data_o;
   logic        ready_i = 1'b0;
   logic        busy_o;
   logic        done_o;
   logic        error_o;

   int checks = 0;
   int errors = 0;

   alu_op_sequencer #(.WIDTH_P(32)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
      .opcode_i(opcode_i), .length_i(length_i),
      .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
      .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
      .alu_opcode_o(alu_opcode_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
      .alu_valid_i(alu_valid_i), .alu_result_i(alu_result_i),
      .alu_ready_o(alu_ready_o), .valid_o(valid_o), .data_o(data_o),
      .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tmo(input string tag);
      checks++;
      errors++;
      $error("FAIL %s timeout waiting for DUT", tag);
   endtask

   task automatic start_cmd(input logic [1:0] op, input logic [15:0] len);
      start_i = 1'b1; opcode_i = op; length_i = len;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic rx_byte(input logic [7:0] b, input int gap);
      int n;
      valid_i = 1'b0;
      repeat (gap) @(negedge clk_i);
      valid_i = 1'b1; data_i = b; n = 0;
      while (ready_o !== 1'b1 && n < 40) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 40) tmo("rx_ready");
      @(negedge clk_i);
      valid_i = 1'b0;
   endtask

   task automatic rx_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) rx_byte(w[8*i +: 8], gap);
   endtask

   task automatic alu_txn(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] res, input int stall);
      int n = 0;
      while (alu_valid_o !== 1'b1 && n < 40) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 40) tmo("alu_valid");
      chk("alu_a", alu_a_o, a);
      chk("alu_b", alu_b_o, b);
      chk("alu_op", 32'(alu_opcode_o), 32'(op));
      for (int s = 0; s < stall; s++) begin
         @(negedge clk_i);
         chk("alu_stall_valid", 32'(alu_valid_o), 32'd1);
         chk("alu_stall_a", alu_a_o, a);
         chk("alu_stall_b", alu_b_o, b);
      end
      alu_ready_i = 1'b1;
      @(negedge clk_i);
      alu_ready_i = 1'b0;
      chk("alu_valid_drop", 32'(alu_valid_o), 32'd0);
      chk("alu_ready_o", 32'(alu_ready_o), 32'd1);
      alu_valid_i = 1'b1; alu_result_i = res;
      @(negedge clk_i);
      alu_valid_i = 1'b0;
      chk("alu_ready_drop", 32'(alu_ready_o), 32'd0);
   endtask

   task automatic tx_collect(input logic [31:0] w, input logic toggle);
      chk("tx_valid", 32'(valid_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (toggle) begin
            ready_i = 1'b0;
            @(negedge clk_i);
            chk("tx_stall_valid", 32'(valid_o), 32'd1);
            chk("tx_stall_data", 32'(data_o), 32'(w[8*i +: 8]));
         end
         ready_i = 1'b1;
         chk("tx_data", 32'(data_o), 32'(w[8*i +: 8]));
         @(negedge clk_i);
         ready_i = 1'b0;
      end
      chk("done_pulse", 32'(done_o), 32'd1);
      chk("tx_valid_end", 32'(valid_o), 32'd0);
      chk("busy_end", 32'(busy_o), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(ready_o), 32'd0);
      chk({tag, "_alu_valid"}, 32'(alu_valid_o), 32'd0);
      chk({tag, "_alu_ready"}, 32'(alu_ready_o), 32'd0);
      chk({tag, "_valid"}, 32'(valid_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      chk({tag, "_done"}, 32'(done_o), 32'd0);
      chk({tag, "_error"}, 32'(error_o), 32'd0);
      chk({tag, "_data"}, 32'(data_o), 32'd0);
      chk({tag, "_a"}, alu_a_o, 32'd0);
      chk({tag, "_b"}, alu_b_o, 32'd0);
      chk({tag, "_op"}, 32'(alu_opcode_o), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk_i);
      chk_reset_outputs("reset");
      reset_i = 1'b0;
      @(negedge clk_i);

      // Add 5 + 3, length 8
      start_cmd(2'd1, 16'd8);
      chk("t1_ready_after_start", 32'(ready_o), 32'd1);
      chk("t1_busy", 32'(busy_o), 32'd1);
      rx_word(32'h0000_0005, 0);
      rx_word(32'h0000_0003, 0);
      chk("t1_issue_next_cycle", 32'(alu_valid_o), 32'd1);
      alu_txn(32'd5, 32'd3, 2'd1, 32'd8, 0);
      tx_collect(32'h0000_0008, 1'b0);
      start_cmd(2'd1, 16'd16);
      chk("t1_done_once", 32'(done_o), 32'd0);

      // Add 1+2+3+4, length 16; second start already accepted above
      chk("t2_ready", 32'(ready_o), 32'd1);
      start_cmd(2'd1, 16'd3);
      chk("t2_start_ignored_err", 32'(error_o), 32'd0);
      chk("t2_start_ignored_rdy", 32'(ready_o), 32'd1);
      rx_word(32'd1, 0);
      rx_word(32'd2, 0);
      alu_txn(32'd1, 32'd2, 2'd1, 32'd3, 0);
      chk("t2_more_ready", 32'(ready_o), 32'd1);
      rx_word(32'd3, 0);
      alu_txn(32'd3, 32'd3, 2'd1, 32'd6, 0);
      rx_word(32'd4, 0);
      alu_txn(32'd6, 32'd4, 2'd1, 32'd10, 0);
      tx_collect(32'h0000_000A, 1'b0);
      @(negedge clk_i);

      // Rejected lengths
      start_cmd(2'd1, 16'd6);
      chk("t3_err6", 32'(error_o), 32'd1);
      chk("t3_busy6", 32'(busy_o), 32'd0);
      chk("t3_ready6", 32'(ready_o), 32'd0);
      @(negedge clk_i);
      chk("t3_err_pulse", 32'(error_o), 32'd0);
      start_cmd(2'd1, 16'd10);
      chk("t3_err10", 32'(error_o), 32'd1);
      chk("t3_busy10", 32'(busy_o), 32'd0);
      chk("t3_ready10", 32'(ready_o), 32'd0);
      start_cmd(2'd1, 16'd4);
      chk("t3_err4", 32'(error_o), 32'd1);
      chk("t3_ready4", 32'(ready_o), 32'd0);
      @(negedge clk_i);

      // Backpressure on both ALU and TX
      start_cmd(2'd1, 16'd8);
      rx_word(32'h1122_3344, 0);
      rx_word(32'h0101_0101, 0);
      alu_txn(32'h1122_3344, 32'h0101_0101, 2'd1, 32'h1223_3445, 5);
      tx_collect(32'h1223_3445, 1'b1);
      @(negedge clk_i);

      // Gappy RX, Mul 7 x 6
      start_cmd(2'd2, 16'd8);
      rx_word(32'd7, 2);
      rx_word(32'd6, 2);
      alu_txn(32'd7, 32'd6, 2'd2, 32'h0000_002A, 0);
      tx_collect(32'h0000_002A, 1'b0);
      @(negedge clk_i);

      // Reset mid-LoadB, then a clean command
      start_cmd(2'd3, 16'd8);
      rx_word(32'hAABB_CCDD, 0);
      rx_byte(8'h11, 0);
      rx_byte(8'h22, 0);
      reset_i = 1'b1;
      @(negedge clk_i);
      chk_reset_outputs("t6");
      reset_i = 1'b0;
      @(negedge clk_i);
      chk("t6_no_done", 32'(done_o), 32'd0);
      start_cmd(2'd1, 16'd8);
      rx_word(32'd9, 0);
      rx_word(32'd4, 0);
      alu_txn(32'd9, 32'd4, 2'd1, 32'd13, 0);
      tx_collect(32'h0000_000D, 1'b0);
      @(negedge clk_i);
      chk("t6_done_clear", 32'(done_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
